// File: rtl/score_keeper.sv
// Score and combo bookkeeping for the rhythm game: judgement pulses become a
// saturating 4-digit BCD score and 2-digit BCD combo, credited through a drain counter.
module score_keeper #(
    parameter int PTS_PERFECT = 3,
    parameter int PTS_GOOD    = 1,
    parameter int PTS_BONUS   = 5
) (
    input  logic        CLK_50M,
    input  logic        rst_n,
    input  logic        on_off,
    input  logic        pau_flag,
    input  logic        hit_perfect,
    input  logic        hit_good,
    input  logic        miss,
    output logic [15:0] score_bcd,
    output logic [7:0]  combo_bcd,
    output logic [7:0]  max_combo_bcd,
    output logic        busy
);

    logic [15:0] score_reg, score_next;
    logic [7:0]  combo_reg, combo_next;
    logic [7:0]  max_combo_reg, max_combo_next;
    logic [5:0]  pending_reg, pending_next;
    logic        busy_reg;

    logic [15:0] score_inc;
    logic [4:0]  score_carry;
    logic [7:0]  combo_inc;
    logic [2:0]  combo_carry;
    logic        score_sat;
    logic        combo_sat;

    logic        hit;
    logic        drain;
    logic [4:0]  add;
    logic [6:0]  pend_sum;

    // Ripple BCD incrementers; a carry out of the top digit means every digit is 9.
    assign score_carry[0] = 1'b1;
    assign combo_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_score_digit
            assign score_inc[gi*4 +: 4] = !score_carry[gi]            ? score_reg[gi*4 +: 4] :
                                          (score_reg[gi*4 +: 4] == 4'd9) ? 4'd0 :
                                          score_reg[gi*4 +: 4] + 4'd1;
            assign score_carry[gi+1] = score_carry[gi] && (score_reg[gi*4 +: 4] == 4'd9);
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_combo_digit
            assign combo_inc[gi*4 +: 4] = !combo_carry[gi]            ? combo_reg[gi*4 +: 4] :
                                          (combo_reg[gi*4 +: 4] == 4'd9) ? 4'd0 :
                                          combo_reg[gi*4 +: 4] + 4'd1;
            assign combo_carry[gi+1] = combo_carry[gi] && (combo_reg[gi*4 +: 4] == 4'd9);
        end
    endgenerate

    assign score_sat = score_carry[4];
    assign combo_sat = combo_carry[2];

    always_comb begin
        hit            = hit_perfect || hit_good;
        combo_next     = combo_reg;
        max_combo_next = max_combo_reg;
        add            = 5'd0;

        if (hit) begin
            add = hit_perfect ? 5'(PTS_PERFECT) : 5'(PTS_GOOD);
            if (!combo_sat) begin
                combo_next = combo_inc;
                // A fresh zero units digit after incrementing means 10, 20, ... 90.
                if (combo_inc[3:0] == 4'd0) begin
                    add = add + 5'(PTS_BONUS);
                end
            end
        end else if (miss) begin
            combo_next = 8'h00;
        end

        // Valid BCD orders the same way as binary.
        if (combo_next > max_combo_reg) begin
            max_combo_next = combo_next;
        end

        drain        = (pending_reg != 6'd0);
        pend_sum     = {1'b0, pending_reg} + {2'b00, add} - {6'd0, drain};
        pending_next = (pend_sum > 7'd63) ? 6'd63 : pend_sum[5:0];
        score_next   = (drain && !score_sat) ? score_inc : score_reg;
    end

    always_ff @(posedge CLK_50M) begin
        if (!rst_n || !on_off) begin
            score_reg     <= 16'h0000;
            combo_reg     <= 8'h00;
            max_combo_reg <= 8'h00;
            pending_reg   <= 6'd0;
            busy_reg      <= 1'b0;
        end else if (!pau_flag) begin
            score_reg     <= score_next;
            combo_reg     <= combo_next;
            max_combo_reg <= max_combo_next;
            pending_reg   <= pending_next;
            busy_reg      <= (pending_next != 6'd0);
        end
    end

    assign score_bcd     = score_reg;
    assign combo_bcd     = combo_reg;
    assign max_combo_bcd = max_combo_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: decimal-integer reference model compared
// every cycle, directed scenarios with literal expectations, then random stimulus.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        on_off = 1'b1;
    logic        pau_flag = 1'b0;
    logic        hit_perfect = 1'b0;
    logic        hit_good = 1'b0;
    logic        miss = 1'b0;
    logic [15:0] score_bcd;
    logic [7:0]  combo_bcd;
    logic [7:0]  max_combo_bcd;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    bit chk_en    = 1'b0;

    int m_score = 0;
    int m_combo = 0;
    int m_max   = 0;
    int m_pend  = 0;

    score_keeper #(.PTS_PERFECT(3), .PTS_GOOD(1), .PTS_BONUS(5)) dut (
        .CLK_50M      (clk),
        .rst_n        (rst_n),
        .on_off       (on_off),
        .pau_flag     (pau_flag),
        .hit_perfect  (hit_perfect),
        .hit_good     (hit_good),
        .miss         (miss),
        .score_bcd    (score_bcd),
        .combo_bcd    (combo_bcd),
        .max_combo_bcd(max_combo_bcd),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain decimal arithmetic on the game rules.
    always @(posedge clk) begin
        int add;
        if (!rst_n || !on_off) begin
            m_score = 0; m_combo = 0; m_max = 0; m_pend = 0;
        end else if (!pau_flag) begin
            add = 0;
            if (m_pend > 0 && m_score < 9999) m_score = m_score + 1;
            if (hit_perfect || hit_good) begin
                add = hit_perfect ? 3 : 1;
                if (m_combo < 99) begin
                    m_combo = m_combo + 1;
                    if (m_combo % 10 == 0) add = add + 5;
                end
            end else if (miss) begin
                m_combo = 0;
            end
            if (m_combo > m_max) m_max = m_combo;
            m_pend = m_pend - ((m_pend > 0) ? 1 : 0) + add;
            if (m_pend > 63) m_pend = 63;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("score", score_bcd, to_bcd(m_score));
            check("combo", {8'h00, combo_bcd}, to_bcd(m_combo));
            check("max_combo", {8'h00, max_combo_bcd}, to_bcd(m_max));
            check("busy", {15'd0, busy}, {15'd0, m_pend != 0});
        end
    end

    task automatic drive(input bit p, input bit g, input bit m);
        hit_perfect = p;
        hit_good    = g;
        miss        = m;
        @(negedge clk);
        #1;
        hit_perfect = 1'b0;
        hit_good    = 1'b0;
        miss        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic clear_game();
        on_off = 1'b0;
        idle(1);
        on_off = 1'b1;
    endtask

    initial begin
        int guard;
        @(negedge clk);
        #1;
        chk_en = 1'b1;

        // Reset held with hits toggling
        for (int i = 0; i < 4; i++) drive(i[0], !i[0], 1'b0);
        check("rst_score", score_bcd, 16'h0000);
        check("rst_combo", {8'h00, combo_bcd}, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0000);
        rst_n = 1'b1;
        idle(1);

        drive(1, 0, 0);
        check("first_combo", {8'h00, combo_bcd}, 16'h0001);
        check("first_busy", {15'd0, busy}, 16'h0001);
        idle(2);
        check("first_busy_k2", {15'd0, busy}, 16'h0001);
        idle(1);
        check("first_score", score_bcd, 16'h0003);
        check("first_busy_done", {15'd0, busy}, 16'h0000);

        // Combo bonus and miss
        clear_game();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0);
            idle(4);
        end
        idle(8);
        check("bonus_combo", {8'h00, combo_bcd}, 16'h0010);
        check("bonus_score", score_bcd, 16'h0015);
        drive(0, 0, 1);
        check("miss_combo", {8'h00, combo_bcd}, 16'h0000);
        check("miss_max", {8'h00, max_combo_bcd}, 16'h0010);
        check("miss_score", score_bcd, 16'h0015);

        // Back-to-back perfects
        clear_game();
        for (int i = 0; i < 4; i++) drive(1, 0, 0);
        check("b2b_combo", {8'h00, combo_bcd}, 16'h0004);
        idle(8);
        check("b2b_busy_k8", {15'd0, busy}, 16'h0001);
        idle(1);
        check("b2b_score", score_bcd, 16'h0012);
        check("b2b_busy", {15'd0, busy}, 16'h0000);

        // Priority
        clear_game();
        drive(1, 1, 1);
        idle(4);
        check("prio_all_combo", {8'h00, combo_bcd}, 16'h0001);
        check("prio_all_score", score_bcd, 16'h0003);
        drive(0, 1, 1);
        idle(2);
        check("prio_gm_combo", {8'h00, combo_bcd}, 16'h0002);
        check("prio_gm_score", score_bcd, 16'h0004);

        // Pause mid-drain with pending=2, pulses during pause dropped
        clear_game();
        drive(1, 0, 0);
        idle(1);
        pau_flag = 1'b1;
        idle(2);
        drive(1, 0, 0);
        idle(2);
        check("pause_score", score_bcd, 16'h0001);
        check("pause_combo", {8'h00, combo_bcd}, 16'h0001);
        pau_flag = 1'b0;
        idle(1);
        check("resume_score1", score_bcd, 16'h0002);
        idle(1);
        check("resume_score2", score_bcd, 16'h0003);
        check("resume_busy", {15'd0, busy}, 16'h0000);

        // Clear mid-drain
        drive(1, 0, 0);
        idle(1);
        on_off = 1'b0;
        idle(1);
        check("clr_score", score_bcd, 16'h0000);
        check("clr_busy", {15'd0, busy}, 16'h0000);
        on_off = 1'b1;
        idle(1);

        // Saturation: preload to 9998 then one perfect
        guard = 0;
        while (m_score + m_pend < 9990 && guard < 20000) begin
            drive(1, 0, 0);
            idle(2);
            guard++;
        end
        guard = 0;
        while (m_pend != 0 && guard < 100) begin idle(1); guard++; end
        guard = 0;
        while (m_score < 9998 && guard < 50) begin
            drive(0, 1, 0);
            idle(2);
            guard++;
        end
        check("sat_preload", score_bcd, 16'h9998);
        check("sat_combo", {8'h00, combo_bcd}, 16'h0099);
        drive(1, 0, 0);
        idle(2);
        check("sat_busy_k2", {15'd0, busy}, 16'h0001);
        idle(1);
        check("sat_score", score_bcd, 16'h9999);
        check("sat_busy", {15'd0, busy}, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 499) != 0);
            on_off   = ($urandom_range(0, 199) != 0);
            pau_flag = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end
        rst_n = 1'b1; on_off = 1'b1; pau_flag = 1'b0;
        idle(70);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
